sequence_transmitter: RTL

SEQUENCE_TRANSMITTER -- requirements
Module: sequence_transmitter

---
 rtl/sequence_transmitter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sequence_transmitter.sv
// Framed serial transmitter: a 1101 sync word, then the payload MSB first,
// with a stuff 0 inserted wherever 110 is about to be followed by a 1.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   data_in    payload word, captured on the handshake edge
//   data_valid upstream request; handshake = data_valid & ready
//   ready      high in IDLE, when a new frame can be accepted
//   tx_out     serial bit stream, one bit per clk
//   tx_active  high while tx_out carries a frame bit
//   stuff_bit  high while tx_out carries an inserted stuff 0
//   frame_done one-cycle pulse in the IDLE cycle after the last bit
module sequence_transmitter #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PAYLOAD_W-1:0] data_in,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 tx_out,
    output logic                 tx_active,
    output logic                 stuff_bit,
    output logic                 frame_done
);

    localparam int         CW        = $clog2(PAYLOAD_W + 1);
    localparam logic [3:0] SYNC_WORD = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } state_t;

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic [CW-1:0]        left_q, left_d;
    logic [1:0]           sync_cnt_q, sync_cnt_d;
    logic [2:0]           hist_q, hist_d;
    logic                 ready_q, ready_d;
    logic                 tx_q, tx_d;
    logic                 active_q, active_d;
    logic                 stuff_q, stuff_d;
    logic                 done_q, done_d;

    // Next payload emission; hist_q already includes the bit on tx_out now.
    logic [1:0]           sync_idx;
    logic                 em_tx;
    logic                 em_stuff;
    logic [PAYLOAD_W-1:0] em_data;
    logic [CW-1:0]        em_left;
    logic [2:0]           em_hist;

    always_comb begin
        sync_idx = 2'd2 - sync_cnt_q;
        em_stuff = (hist_q == 3'b110) && data_q[PAYLOAD_W-1];
        em_tx    = 1'b0;
        em_data  = data_q;
        em_left  = left_q;
        if (!em_stuff) begin
            em_tx   = data_q[PAYLOAD_W-1];
            em_data = {data_q[PAYLOAD_W-2:0], 1'b0};
            em_left = left_q - CW'(1);
        end
        em_hist = {hist_q[1:0], em_tx};
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        left_d     = left_q;
        sync_cnt_d = sync_cnt_q;
        hist_d     = hist_q;
        ready_d    = ready_q;
        tx_d       = tx_q;
        active_d   = active_q;
        stuff_d    = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d  = 1'b1;
                tx_d     = 1'b0;
                active_d = 1'b0;
                hist_d   = 3'b000;
                if (data_valid && ready_q) begin
                    state_d    = SYNC;
                    data_d     = data_in;
                    left_d     = CW'(PAYLOAD_W);
                    sync_cnt_d = 2'd0;
                    hist_d     = 3'b001;
                    ready_d    = 1'b0;
                    tx_d       = 1'b1;
                    active_d   = 1'b1;
                end
            end
            SYNC: begin
                if (sync_cnt_q != 2'd3) begin
                    sync_cnt_d = sync_cnt_q + 2'd1;
                    tx_d       = SYNC_WORD[sync_idx];
                    hist_d     = {hist_q[1:0], SYNC_WORD[sync_idx]};
                end else begin
                    state_d = DATA;
                    tx_d    = em_tx;
                    stuff_d = em_stuff;
                    data_d  = em_data;
                    left_d  = em_left;
                    hist_d  = em_hist;
                end
            end
            DATA: begin
                if (left_q == '0) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    tx_d     = 1'b0;
                    active_d = 1'b0;
                    hist_d   = 3'b000;
                    done_d   = 1'b1;
                end else begin
                    tx_d    = em_tx;
                    stuff_d = em_stuff;
                    data_d  = em_data;
                    left_d  = em_left;
                    hist_d  = em_hist;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            left_q     <= '0;
            sync_cnt_q <= 2'd0;
            hist_q     <= 3'b000;
            ready_q    <= 1'b1;
            tx_q       <= 1'b0;
            active_q   <= 1'b0;
            stuff_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            left_q     <= left_d;
            sync_cnt_q <= sync_cnt_d;
            hist_q     <= hist_d;
            ready_q    <= ready_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
            stuff_q    <= stuff_d;
            done_q     <= done_d;
        end
    end

    assign ready      = ready_q;
    assign tx_out     = tx_q;
    assign tx_active  = active_q;
    assign stuff_bit  = stuff_q;
    assign frame_done = done_q;

endmodule
